// File: rtl/alu_seq_n_bits.sv
// Registered N-bit ALU with start/busy/done handshake.
// MUL is an N-cycle shift-add; DIV/MOD share an N-cycle restoring divider.
module alu_seq_n_bits #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   control,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z,
    output logic         dz,
    output logic         err
);

    localparam int unsigned CW = $clog2(N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_MOD = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  opa, opa_nxt;
    logic [N-1:0]  opb, opb_nxt;
    logic [3:0]    op, op_nxt;
    logic [N-1:0]  hi, hi_nxt;
    logic [N-1:0]  lo, lo_nxt;

    logic          fin;
    logic [N-1:0]  fin_res;
    logic          fin_c, fin_v, fin_dz, fin_err;

    // single-cycle unit, evaluated on the live inputs at the accept edge
    logic [N-1:0]  b_eff;
    logic [N:0]    add_sum;
    logic          shift_big;
    logic [N-1:0]  oc_res;
    logic          oc_c, oc_v, oc_dz, oc_err, oc_iter;

    always_comb begin
        b_eff     = (control == OP_SUB) ? ~b : b;
        add_sum   = {1'b0, a} + {1'b0, b_eff} + (N+1)'(control == OP_SUB);
        shift_big = ({1'b0, b} >= (N+1)'(N));
        oc_res    = '0;
        oc_c      = 1'b0;
        oc_v      = 1'b0;
        oc_dz     = 1'b0;
        oc_err    = 1'b0;
        oc_iter   = 1'b0;
        case (control)
            OP_ADD, OP_SUB: begin
                oc_res = add_sum[N-1:0];
                oc_c   = add_sum[N];
                oc_v   = (a[N-1] == b_eff[N-1]) && (add_sum[N-1] != a[N-1]);
            end
            OP_AND: oc_res = a & b;
            OP_OR:  oc_res = a | b;
            OP_XOR: oc_res = a ^ b;
            OP_LSR: oc_res = shift_big ? '0 : (a >> b);
            OP_LSL: oc_res = shift_big ? '0 : (a << b);
            OP_MOD: begin
                if (b == '0) begin
                    oc_res = a;
                    oc_dz  = 1'b1;
                end else begin
                    oc_iter = 1'b1;
                end
            end
            OP_MUL: oc_iter = 1'b1;
            OP_DIV: begin
                if (b == '0) begin
                    oc_res = '1;
                    oc_dz  = 1'b1;
                end else begin
                    oc_iter = 1'b1;
                end
            end
            default: oc_err = 1'b1;
        endcase
    end

    // one iteration step: hi/lo hold product halves (MUL) or remainder/quotient (DIV/MOD)
    logic [N:0]   mul_sum;
    logic [N-1:0] mul_hi, mul_lo;
    logic [N:0]   div_sh, div_df;
    logic         div_ge;
    logic [N-1:0] div_hi, div_lo;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opa} : (N+1)'(0));
        mul_hi  = mul_sum[N:1];
        mul_lo  = {mul_sum[0], lo[N-1:1]};
        div_sh  = {hi, lo[N-1]};
        div_ge  = (div_sh >= {1'b0, opb});
        div_df  = div_sh - {1'b0, opb};
        div_hi  = div_ge ? div_df[N-1:0] : div_sh[N-1:0];
        div_lo  = {lo[N-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        opa_nxt   = opa;
        opb_nxt   = opb;
        op_nxt    = op;
        hi_nxt    = hi;
        lo_nxt    = lo;
        fin       = 1'b0;
        fin_res   = '0;
        fin_c     = 1'b0;
        fin_v     = 1'b0;
        fin_dz    = 1'b0;
        fin_err   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    opa_nxt = a;
                    opb_nxt = b;
                    op_nxt  = control;
                    if (oc_iter) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        hi_nxt    = '0;
                        lo_nxt    = (control == OP_MUL) ? b : a;
                    end else begin
                        fin     = 1'b1;
                        fin_res = oc_res;
                        fin_c   = oc_c;
                        fin_v   = oc_v;
                        fin_dz  = oc_dz;
                        fin_err = oc_err;
                    end
                end
            end
            RUN: begin
                cnt_nxt = cnt + CW'(1);
                if (op == OP_MUL) begin
                    hi_nxt = mul_hi;
                    lo_nxt = mul_lo;
                end else begin
                    hi_nxt = div_hi;
                    lo_nxt = div_lo;
                end
                if (cnt == CW'(N - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    fin       = 1'b1;
                    if (op == OP_MUL) begin
                        fin_res = mul_lo;
                        fin_c   = |mul_hi;
                        fin_v   = |mul_hi;
                    end else if (op == OP_DIV) begin
                        fin_res = div_lo;
                    end else begin
                        fin_res = div_hi;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            op     <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            result <= '0;
            v      <= 1'b0;
            c      <= 1'b0;
            n      <= 1'b0;
            z      <= 1'b0;
            dz     <= 1'b0;
            err    <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            opa  <= opa_nxt;
            opb  <= opb_nxt;
            op   <= op_nxt;
            hi   <= hi_nxt;
            lo   <= lo_nxt;
            done <= fin;
            if (fin) begin
                result <= fin_res;
                v      <= fin_v;
                c      <= fin_c;
                n      <= fin_res[N-1];
                z      <= (fin_res == '0);
                dz     <= fin_dz;
                err    <= fin_err;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Bench for alu_seq_n_bits: directed literal cases plus randomized traffic
// checked every cycle against a cycle-level arithmetic model.
module tb_alu_seq_n_bits;

    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   control = '0;
    logic         busy, done, v, c, n, z, dz, err;
    logic [N-1:0] result;

    always #5 clk = ~clk;

    alu_seq_n_bits #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .control(control),
        .busy(busy), .done(done), .result(result),
        .v(v), .c(c), .n(n), .z(z), .dz(dz), .err(err)
    );

    typedef struct {
        int res;
        bit v, c, n, z, dz, err, iter;
    } exp_t;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t model(input int x, input int y, input int op);
        exp_t e;
        int s, yb, p;
        e = '{default: 0};
        case (op)
            0, 1: begin
                yb    = (op == 1) ? (M - 1 - y) : y;
                s     = x + yb + ((op == 1) ? 1 : 0);
                e.res = s % M;
                e.c   = (s >= M);
                e.v   = ((x >= M/2) == (yb >= M/2)) && ((e.res >= M/2) != (x >= M/2));
            end
            2: e.res = x & y;
            3: e.res = x | y;
            4: e.res = x ^ y;
            5: e.res = (y >= N) ? 0 : (x >> y);
            6: e.res = (y >= N) ? 0 : ((x << y) % M);
            7: begin
                if (y == 0) begin e.res = x; e.dz = 1; end
                else begin e.res = x % y; e.iter = 1; end
            end
            8: begin
                p      = x * y;
                e.res  = p % M;
                e.c    = (p / M) != 0;
                e.v    = e.c;
                e.iter = 1;
            end
            9: begin
                if (y == 0) begin e.res = M - 1; e.dz = 1; end
                else begin e.res = x / y; e.iter = 1; end
            end
            default: e.err = 1;
        endcase
        e.z = (e.res == 0);
        e.n = (e.res >= M/2);
        return e;
    endfunction

    // cycle-level model: visible outputs, remaining busy cycles, pending completion
    int   m_result;
    bit   m_v, m_c, m_n, m_z, m_dz, m_err, m_done, m_valid;
    int   m_left;
    exp_t m_pend;

    task automatic apply(input exp_t e);
        m_result = e.res;
        m_v = e.v; m_c = e.c; m_n = e.n; m_z = e.z; m_dz = e.dz; m_err = e.err;
        m_done = 1;
    endtask

    initial begin
        m_valid = 0; m_left = 0; m_done = 0; m_result = 0;
        m_v = 0; m_c = 0; m_n = 0; m_z = 0; m_dz = 0; m_err = 0;
    end

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_result = 0;
            m_v = 0; m_c = 0; m_n = 0; m_z = 0; m_dz = 0; m_err = 0;
            m_done = 0; m_left = 0; m_valid = 1;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) apply(m_pend);
            end else if (start) begin
                e = model(int'(a), int'(b), int'(control));
                if (e.iter) begin
                    m_pend = e;
                    m_left = N;
                end else begin
                    apply(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",   busy,   (m_left > 0) ? 1 : 0);
            check("done",   done,   m_done);
            check("result", result, m_result);
            check("v",  v,  m_v);
            check("c",  c,  m_c);
            check("n",  n,  m_n);
            check("z",  z,  m_z);
            check("dz", dz, m_dz);
            check("err", err, m_err);
        end
    end

    task automatic go(input int xa, input int xb, input int xop);
        a       = N'(xa);
        b       = N'(xb);
        control = 4'(xop);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // returns number of negedges up to and including the one that shows done
    task automatic wait_done(input bit noisy, output int cyc);
        bit ok;
        ok  = 0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin ok = 1; break; end
            if (noisy && busy) begin
                start   = 1'($urandom % 2);
                a       = N'($urandom);
                b       = N'($urandom);
                control = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!ok) check("done_timeout", 0, 1);
    endtask

    initial begin
        int cyc;
        exp_t e;
        int xa, xb, xop;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_result", result, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        go(7, 1, 0); wait_done(0, cyc);
        check("add71_lat", cyc, 1);
        check("add71_res", result, 8);
        check("add71_n", n, 1); check("add71_v", v, 1);
        check("add71_c", c, 0); check("add71_z", z, 0);

        go(3, 3, 1); wait_done(0, cyc);
        check("sub33_res", result, 0); check("sub33_z", z, 1);
        check("sub33_c", c, 1); check("sub33_v", v, 0);

        go(2, 5, 1); wait_done(0, cyc);
        check("sub25_res", result, 13); check("sub25_n", n, 1); check("sub25_c", c, 0);

        go(5, 3, 8); wait_done(0, cyc);
        check("mul53_lat", cyc, N + 1);
        check("mul53_res", result, 15); check("mul53_c", c, 0); check("mul53_v", v, 0);

        go(6, 3, 8); wait_done(0, cyc);
        check("mul63_res", result, 2); check("mul63_c", c, 1); check("mul63_v", v, 1);

        go(13, 4, 9); wait_done(0, cyc);
        check("div134_res", result, 3);
        go(13, 4, 7); wait_done(0, cyc);
        check("mod134_res", result, 1);
        go(9, 0, 9); wait_done(0, cyc);
        check("div90_lat", cyc, 1); check("div90_res", result, 15); check("div90_dz", dz, 1);
        go(9, 0, 7); wait_done(0, cyc);
        check("mod90_res", result, 9); check("mod90_dz", dz, 1);

        go(1, 5, 6); wait_done(0, cyc);
        check("lsl15_res", result, 0); check("lsl15_z", z, 1); check("lsl15_dz", dz, 0);
        go(4, 4, 12); wait_done(0, cyc);
        check("op12_err", err, 1); check("op12_res", result, 0);
        go(15, 6, 2); wait_done(0, cyc);
        check("and_res", result, 6); check("and_err", err, 0);

        // back-to-back: new start issued in the done cycle
        go(2, 3, 0); wait_done(0, cyc);
        go(3, 4, 0); wait_done(0, cyc);
        check("b2b_lat", cyc, 1); check("b2b_res", result, 7);
        go(7, 2, 8); wait_done(0, cyc);
        check("b2b_mul_lat", cyc, N + 1); check("b2b_mul_res", result, 14);

        // start pulsed mid-MUL must be ignored
        go(5, 3, 8);
        @(posedge clk); #1;
        a = 4'd1; b = 4'd1; control = 4'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(0, cyc);
        check("ignored_res", result, 15);
        repeat (3) @(negedge clk);

        // reset on the second RUN cycle aborts without done
        go(6, 3, 8);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0); check("abort_done", done, 0);
        check("abort_res", result, 0);
        repeat (6) @(negedge clk);
        go(1, 1, 0); wait_done(0, cyc);
        check("post_reset_add", result, 2);

        for (int k = 0; k < 200; k++) begin
            xa  = int'($urandom_range(0, M - 1));
            xb  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, M - 1));
            xop = int'($urandom_range(0, 15));
            e   = model(xa, xb, xop);
            go(xa, xb, xop);
            wait_done(1, cyc);
            check("rand_latency", cyc, e.iter ? N + 1 : 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq_n_bits.md
Name: alu_seq_n_bits

Overview:
- Registered, multi-cycle successor to the combinational N-bit ALU.
- Opcode map is unchanged (0–9).
- ADD/SUB/AND/OR/XOR/LSR/LSL complete in one cycle. MUL uses an N-cycle shift-add and DIV/MOD use an N-cycle restoring divider, which removes the wide combinational `*`, `/` and `%`.
- Adds a start/busy/done handshake, divide-by-zero and illegal-opcode reporting, and MUL overflow flags. It sits between the operand/opcode source (buttons or controller FSM) and the 7-segment/flag outputs.

Parameters:
- N, 4: operand and result width in bits; N >= 2.

Ports:
- clk, input, 1: single system clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: request; sampled only when busy=0.
- a, input, N: operand A, unsigned (two's complement for the v flag).
- b, input, N: operand B or shift amount.
- control, input, 4: opcode. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSR, 6 LSL, 7 MOD, 8 MUL, 9 DIV; 10–15 illegal.
- busy, output, 1: iterative operation in progress.
- done, output, 1: one-cycle pulse; result and flags are valid.
- result, output, N: registered result; held until the next completion.
- v, output, 1: overflow flag, registered.
- c, output, 1: carry flag, registered.
- n, output, 1: negative flag, registered.
- z, output, 1: zero flag, registered.
- dz, output, 1: divide-by-zero on the last completed operation.
- err, output, 1: illegal opcode on the last completed operation.

Behaviour:
- Reset:
  - When rst_n=0 at a rising edge, state goes to IDLE and the iteration counter and work registers clear.
  - result=0, v=c=n=z=0, dz=err=0, busy=0, done=0.
  - Reset is honoured in any state, including mid-iteration. The aborted operation produces no done.
- States: IDLE, RUN. busy=1 exactly when state=RUN.
- Accept: start=1 while in IDLE. a, b and control are captured at that edge; later input changes have no effect.
- One-cycle ops (0–6, illegal opcodes, DIV/MOD with b=0):
  - result, flags, dz and err update at the accept edge; done=1 for the following cycle.
  - Latency is 1 cycle. State stays IDLE.
- Iterative ops (8, or 7/9 with b≠0):
  - The accept edge enters RUN with counter=0.
  - Each RUN cycle processes one bit; counter increments.
  - On the edge where counter=N-1: result and flags are written, state returns to IDLE, and done=1 for the next cycle.
  - busy is high for exactly N cycles. done is visible N+1 cycles after the start cycle.
- Back-to-back: start may be high in the done cycle (state is IDLE) and is accepted.
- start while busy=1 is ignored (not queued).
- done is low in every cycle other than the single completion pulse.
- Arithmetic:
  - ADD: result = a+b mod 2^N; c = carry-out.
  - SUB: result = a + ~b + 1; c = carry-out (1 = no borrow).
  - v (ADD/SUB) = signed overflow: operand signs are equal, after B inversion for SUB, and the result sign differs.
  - AND/OR/XOR: bitwise.
  - LSR/LSL: logical shift by unsigned b; shift >= N gives 0.
  - MUL: full 2N-bit product; result = low N bits; c = v = OR of the high N bits.
  - DIV: unsigned quotient. MOD: unsigned remainder.
  - b=0 with DIV: result = all ones, dz=1. b=0 with MOD: result = a, dz=1.
  - Illegal opcode: result = 0, err=1.
- Flags:
  - z = (result==0) and n = result[N-1], for every opcode.
  - c and v are 0 for all ops except ADD, SUB and MUL.
  - dz and err clear on the next completion that does not raise them.

Test Plan:
- N=4, ADD a=7, b=1: done the cycle after start; result=8, n=1, v=1, c=0, z=0; busy never high.
- SUB a=3, b=3: result=0, z=1, c=1, v=0. SUB a=2, b=5: result=D, n=1, c=0.
- MUL a=5, b=3: busy high 4 cycles, done on cycle 5; result=F, c=v=0. MUL a=6, b=3: result=2, c=v=1.
- DIV a=13, b=4: result=3. MOD a=13, b=4: result=1. DIV a=9, b=0: result=F, dz=1, done after 1 cycle. MOD a=9, b=0: result=9, dz=1.
- Start pulsed during MUL RUN: ignored, only one done. rst_n=0 on the 2nd RUN cycle: the next cycle has busy=0, done=0, result=0. A fresh ADD 1+1 then gives 2.
- LSL a=1, b=5: result=0, z=1. Opcode 12: err=1, result=0. A following AND F&6: result=6, err=0. Back-to-back start in the done cycle: accepted.
